memory_bus_arbiter: RTL
=======================

Name: memory_bus_arbiter

Overview:
- Shares the single memory_bus port between two masters: the CPU core (port 0) and a DMA/video fetch engine (port 1).
- Latches one request at a time and drives address, write data and strobes to memory_bus.
- Honours memory_bus bus_halt, for example while the SD-card ROM window is busy.
- Returns the read data to the winning master with a one-cycle ack pulse.

Parameters:
- ADDR_WIDTH, 24, width of the address on all ports.
- SETTLE_CYCLES, 1, number of halt-free WAIT cycles before mem_data_out is sampled (covers the block-RAM read latency). Legal range 1-15.
- MAX_WAIT, 16, DMA starvation threshold in cycles. Used only when ARB_STARVE_GUARD_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_req  input  1  CPU access request, level-sensitive.
- cpu_write  input  1  1 = write, 0 = read; qualified by cpu_req.
- cpu_address  input  ADDR_WIDTH  CPU address.
- cpu_wdata  input  8  CPU write data.
- cpu_rdata  output  8  CPU read data; valid while cpu_ack=1, then held.
- cpu_ack  output  1  one-cycle completion pulse.
- dma_req, dma_write, dma_address, dma_wdata, dma_rdata, dma_ack: same directions, widths and meanings as the cpu_* ports, for port 1.
- mem_address  output  ADDR_WIDTH  to memory_bus address.
- mem_data_in  output  8  to memory_bus data_in.
- mem_data_out  input  8  from memory_bus data_out.
- mem_bus_enable  output  1  to memory_bus bus_enable.
- mem_write_enable  output  1  to memory_bus write_enable.
- mem_bus_halt  input  1  from memory_bus bus_halt.
- owner  output  1  0 = CPU, 1 = DMA; the latched owner of the current or last transaction.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs go to 0, including rdata registers, acks, owner, mem_* outputs and the settle counter.
  - An in-flight transaction is aborted with no ack.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - mem_bus_enable=0 and mem_write_enable=0.
  - If any req=1, pick a winner: CPU wins ties (see Optional Feature).
  - Latch the winner's address, wdata and write into internal registers, set owner, go to ISSUE.
  - If no req, stay in IDLE.
- ISSUE (1 cycle):
  - mem_address and mem_data_in come from the latched values; mem_bus_enable=1; mem_write_enable equals the latched write.
  - Load the settle counter with SETTLE_CYCLES, go to WAIT.
  - mem_bus_halt is ignored in this state.
- WAIT:
  - Same drive as ISSUE.
  - If mem_bus_halt=1, stay in WAIT and reload the counter with SETTLE_CYCLES.
  - Otherwise decrement the counter. When it reaches 0, capture mem_data_out into the owner's rdata (reads only; on writes rdata is unchanged) and go to ACK.
- ACK (1 cycle):
  - The owner's ack=1; mem_bus_enable=0 and mem_write_enable=0.
  - Next state is IDLE.
- Latency: with no halt and SETTLE_CYCLES=1, a request seen in IDLE at cycle N gives ack at cycle N+3. Each halted cycle adds 1.
- Request inputs are sampled only in IDLE. Changes to req, address or data during ISSUE, WAIT or ACK are ignored.
- A req still high in IDLE after its ack starts a new transaction. Masters drop req on the ack cycle for single accesses.
- At most one ack is high per cycle; acks never overlap.
- Back-to-back accesses: there is a minimum of 1 IDLE cycle between transactions, so peak throughput is 1 access per 4 cycles.
- The address is held stable from ISSUE through the last WAIT cycle. The ram block's one-cycle read on raw_clk is therefore satisfied.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A 5-bit saturating counter increments each cycle that dma_req=1 and the arbiter is not granting DMA.
  - It clears on DMA grant and on reset.
  - In IDLE, if the counter is at least MAX_WAIT and dma_req=1, DMA wins even when cpu_req=1.
- Not defined:
  - No counter exists; CPU has strict fixed priority.

Test Plan:
- Reset mid-transaction: assert reset low during WAIT → all outputs 0 at once; no ack; FSM in IDLE after release.
- CPU read: preload ram 0x0010=0xA5; cpu_req, cpu_address=0x000010, cpu_write=0 → cpu_ack at req cycle+3; cpu_rdata=0xA5; owner=0; dma_ack never high.
- DMA write then CPU read-back: dma write 0x5A to 0x000020, then cpu read 0x000020 → dma_ack then cpu_ack; cpu_rdata=0x5A.
- Halt stretch: hold mem_bus_halt=1 for 7 cycles during WAIT, address 0x010000 → ack delayed to cycle+10; mem_address stable throughout; mem_bus_enable high through every WAIT cycle.
- Contention: cpu_req and dma_req high together, CPU re-requesting each IDLE → without the macro, DMA never acks for 100 cycles. With ARB_STARVE_GUARD_EN and MAX_WAIT=16, dma_ack occurs within 16+4 cycles.
- Request change: change cpu_address from 0x000030 to 0x000040 during WAIT → access completes to 0x000030.

Source files
------------

// File: rtl/memory_bus_arbiter.sv
// rtl/memory_bus_arbiter.sv - two-master memory_bus arbiter (port 0 CPU, port 1 DMA/video fetch)
// Optional macro ARB_STARVE_GUARD_EN: DMA wins once it has waited MAX_WAIT cycles.
module memory_bus_arbiter #(
    parameter int ADDR_WIDTH    = 24,
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_WAIT      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_ack,
    input  logic                  dma_req,
    input  logic                  dma_write,
    input  logic [ADDR_WIDTH-1:0] dma_address,
    input  logic [7:0]            dma_wdata,
    output logic [7:0]            dma_rdata,
    output logic                  dma_ack,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]            mem_data_in,
    input  logic [7:0]            mem_data_out,
    output logic                  mem_bus_enable,
    output logic                  mem_write_enable,
    input  logic                  mem_bus_halt,
    output logic                  owner
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] lat_address;
    logic [7:0]            lat_wdata;
    logic                  lat_write;
    logic [3:0]            settle_cnt;
    logic                  any_req;
    logic                  grant_dma;
    logic                  settle_done;

    assign any_req     = cpu_req | dma_req;
    assign settle_done = !mem_bus_halt && (settle_cnt == 4'd1);

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [4:0] STARVE_LIMIT = 5'(MAX_WAIT);
    logic [4:0] starve_cnt;

    assign grant_dma = dma_req & (~cpu_req | (starve_cnt >= STARVE_LIMIT));

    // Counts every cycle DMA is asking but not being granted; saturates at 31.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE && grant_dma) begin
            starve_cnt <= '0;
        end else if (dma_req && starve_cnt != 5'd31) begin
            starve_cnt <= starve_cnt + 5'd1;
        end
    end
`else
    localparam int unused_max_wait = MAX_WAIT;
    assign grant_dma = dma_req & ~cpu_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            lat_address <= '0;
            lat_wdata   <= '0;
            lat_write   <= 1'b0;
            owner       <= 1'b0;
            settle_cnt  <= '0;
            cpu_rdata   <= '0;
            dma_rdata   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner       <= grant_dma;
                        lat_address <= grant_dma ? dma_address : cpu_address;
                        lat_wdata   <= grant_dma ? dma_wdata : cpu_wdata;
                        lat_write   <= grant_dma ? dma_write : cpu_write;
                    end
                end
                ISSUE: settle_cnt <= SETTLE_LOAD;
                WAIT: begin
                    if (mem_bus_halt) begin
                        settle_cnt <= SETTLE_LOAD;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                        if (settle_done && !lat_write) begin
                            if (owner) dma_rdata <= mem_data_out;
                            else       cpu_rdata <= mem_data_out;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next       = state;
        mem_bus_enable   = 1'b0;
        mem_write_enable = 1'b0;
        cpu_ack          = 1'b0;
        dma_ack          = 1'b0;
        case (state)
            IDLE: if (any_req) state_next = ISSUE;
            ISSUE: begin
                mem_bus_enable   = 1'b1;
                mem_write_enable = lat_write;
                state_next       = WAIT;
            end
            WAIT: begin
                mem_bus_enable   = 1'b1;
                mem_write_enable = lat_write;
                if (settle_done) state_next = ACK;
            end
            ACK: begin
                cpu_ack    = ~owner;
                dma_ack    = owner;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latched values drive the bus continuously so the address never moves mid-access.
    assign mem_address = lat_address;
    assign mem_data_in = lat_wdata;

endmodule
